// File: rtl/pmem_fetch_arbiter_pkg.sv
// Shared types and constants for the program-memory fetch arbiter.
package pmem_fetch_arbiter_pkg;

  // Number of combinational read ports on program_mem that the arbiter shares.
  localparam int NUM_PMEM_PORTS = 2;

  // Per-channel fetch state.
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_READ = 2'd1,
    CH_RESP = 2'd2
  } pmem_ch_state_t;

endpackage

// File: rtl/pmem_fetch_arbiter_rr_pick2.sv
// Combinational two-winner round-robin picker. Scans cores starting at
// rr_ptr_i. The first eligible core goes to the lowest-numbered free channel.
// The second eligible core goes to channel 1, and only when both channels are free.
module pmem_fetch_arbiter_rr_pick2 #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0]  eligible_i,
  input  logic [IDX_W-1:0]      rr_ptr_i,
  input  logic [1:0]            chan_free_i,
  output logic [1:0]            grant_valid_o,
  output logic [1:0][IDX_W-1:0] grant_idx_o
);

  logic             first_found;
  logic             second_found;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] second_idx;

  // Find the first two eligible cores in round-robin order from rr_ptr_i.
  always_comb begin
    int k;
    k            = 0;
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      k = int'(rr_ptr_i) + i;
      if (k >= NUM_CORES) k = k - NUM_CORES;
      if (eligible_i[k]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = IDX_W'(k);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = IDX_W'(k);
        end
      end
    end
  end

  // Map the winners onto free channels. A core never takes two channels.
  always_comb begin
    grant_valid_o = '0;
    grant_idx_o   = '0;
    if (first_found) begin
      if (chan_free_i[0]) begin
        grant_valid_o[0] = 1'b1;
        grant_idx_o[0]   = first_idx;
        if (second_found && chan_free_i[1]) begin
          grant_valid_o[1] = 1'b1;
          grant_idx_o[1]   = second_idx;
        end
      end else if (chan_free_i[1]) begin
        grant_valid_o[1] = 1'b1;
        grant_idx_o[1]   = first_idx;
      end
    end
  end

endmodule

// File: rtl/pmem_fetch_arbiter.sv
// Shares the two program_mem read ports among NUM_CORES instruction fetchers.
// Each channel registers a granted address, captures the read word one cycle
// later, and holds it for the requesting core until the request is dropped.
//
// Handshake: a core raises core_read_valid[k] and keeps it high until it sees
// core_read_ready[k]. The address is sampled only at grant. Ready stays high
// with stable data for as long as valid[k] remains high. The channel frees on
// the first edge where valid[k] is seen low.
module pmem_fetch_arbiter
  import pmem_fetch_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int PMEM_ADDR_BITS = 8,
  parameter int PMEM_DATA_BITS = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CORES-1:0]                         core_read_valid,
  input  logic [NUM_CORES-1:0][PMEM_ADDR_BITS-1:0]     core_read_address,
  output logic [NUM_CORES-1:0]                         core_read_ready,
  output logic [NUM_CORES-1:0][PMEM_DATA_BITS-1:0]     core_read_data,
  output logic [PMEM_ADDR_BITS-1:0]                    pmem1,
  output logic [PMEM_ADDR_BITS-1:0]                    pmem2,
  input  logic [PMEM_DATA_BITS-1:0]                    pmem1_data,
  input  logic [PMEM_DATA_BITS-1:0]                    pmem2_data,
  output pmem_ch_state_t [NUM_PMEM_PORTS-1:0]          dbg_ch_state
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  pmem_ch_state_t [NUM_PMEM_PORTS-1:0]                 ch_state_q, ch_state_d;
  logic [NUM_PMEM_PORTS-1:0][IDX_W-1:0]                chan_core_q, chan_core_d;
  logic [NUM_PMEM_PORTS-1:0][PMEM_ADDR_BITS-1:0]       pmem_addr_q, pmem_addr_d;
  logic [NUM_CORES-1:0]                                busy_q, busy_d;
  logic [NUM_CORES-1:0]                                ready_q, ready_d;
  logic [NUM_CORES-1:0][PMEM_DATA_BITS-1:0]            data_q, data_d;
  logic [IDX_W-1:0]                                    rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0]                                eligible;
  logic [NUM_PMEM_PORTS-1:0]                           chan_free;
  logic [NUM_PMEM_PORTS-1:0]                           grant_valid;
  logic [NUM_PMEM_PORTS-1:0][IDX_W-1:0]                grant_idx;
  logic [NUM_PMEM_PORTS-1:0][PMEM_DATA_BITS-1:0]       chan_rdata;
  logic [IDX_W-1:0]                                    last_grant;

  // A channel leaving CH_RESP is not idle yet. That alone blocks a grant into it.
  always_comb begin
    eligible = core_read_valid & ~busy_q;
    for (int c = 0; c < NUM_PMEM_PORTS; c++) begin
      chan_free[c] = (ch_state_q[c] == CH_IDLE);
    end
    chan_rdata[0] = pmem1_data;
    chan_rdata[1] = pmem2_data;
  end

  pmem_fetch_arbiter_rr_pick2 #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .eligible_i    (eligible),
    .rr_ptr_i      (rr_ptr_q),
    .chan_free_i   (chan_free),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // When both channels grant, the channel-1 winner came later in the scan.
  always_comb begin
    if (grant_valid[1]) last_grant = grant_idx[1];
    else                last_grant = grant_idx[0];
  end

  // Channel FSMs, busy/ready/data vectors and round-robin pointer next state.
  always_comb begin
    ch_state_d  = ch_state_q;
    chan_core_d = chan_core_q;
    pmem_addr_d = pmem_addr_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    for (int c = 0; c < NUM_PMEM_PORTS; c++) begin
      case (ch_state_q[c])
        CH_IDLE: begin
          if (grant_valid[c]) begin
            ch_state_d[c]          = CH_READ;
            chan_core_d[c]         = grant_idx[c];
            pmem_addr_d[c]         = core_read_address[grant_idx[c]];
            busy_d[grant_idx[c]]   = 1'b1;
          end
        end
        CH_READ: begin
          data_d[chan_core_q[c]]  = chan_rdata[c];
          ready_d[chan_core_q[c]] = 1'b1;
          ch_state_d[c]           = CH_RESP;
        end
        CH_RESP: begin
          if (!core_read_valid[chan_core_q[c]]) begin
            ready_d[chan_core_q[c]] = 1'b0;
            busy_d[chan_core_q[c]]  = 1'b0;
            ch_state_d[c]           = CH_IDLE;
          end
        end
        default: ch_state_d[c] = CH_IDLE;
      endcase
    end
    if (|grant_valid) begin
      if (last_grant == IDX_W'(NUM_CORES - 1)) rr_ptr_d = '0;
      else                                     rr_ptr_d = last_grant + 1'b1;
    end
  end

  // State registers. Reset drops every outstanding fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_state_q  <= {NUM_PMEM_PORTS{CH_IDLE}};
      chan_core_q <= '0;
      pmem_addr_q <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
    end else begin
      ch_state_q  <= ch_state_d;
      chan_core_q <= chan_core_d;
      pmem_addr_q <= pmem_addr_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign core_read_ready = ready_q;
  assign core_read_data  = data_q;
  assign pmem1           = pmem_addr_q[0];
  assign pmem2           = pmem_addr_q[1];
  assign dbg_ch_state    = ch_state_q;

endmodule

// File: tb/tb_pmem_fetch_arbiter.sv
// Directed bench for pmem_fetch_arbiter with a behavioural program memory.
module tb_pmem_fetch_arbiter;
  import pmem_fetch_arbiter_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [3:0]            valid;
  logic [3:0][7:0]       addr;
  logic [3:0]            ready;
  logic [3:0][15:0]      data;
  logic [7:0]            pmem1, pmem2;
  logic [15:0]           pmem1_data, pmem2_data;
  pmem_ch_state_t [1:0]  dbg_state;

  logic [15:0] mem [256];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          order_q[$];
  int          done_cnt[4];
  logic [3:0]  prev_ready;
  int          exp_order[6] = '{0, 1, 2, 3, 0, 1};

  pmem_fetch_arbiter #(
    .NUM_CORES      (4),
    .PMEM_ADDR_BITS (8),
    .PMEM_DATA_BITS (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .core_read_valid   (valid),
    .core_read_address (addr),
    .core_read_ready   (ready),
    .core_read_data    (data),
    .pmem1             (pmem1),
    .pmem2             (pmem2),
    .pmem1_data        (pmem1_data),
    .pmem2_data        (pmem2_data),
    .dbg_ch_state      (dbg_state)
  );

  assign pmem1_data = mem[pmem1];
  assign pmem2_data = mem[pmem2];

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    valid = '0;
    addr  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h05] = 16'hA1B2;
    mem[8'h10] = 16'h1010;
    mem[8'h11] = 16'h2211;
    mem[8'h20] = 16'hC020;
    mem[8'h30] = 16'hD030;
    mem[8'h33] = 16'h3333;
    for (int k = 0; k < 4; k++) mem[8'h40 + k] = 16'h4040 + 16'(k) * 16'h0101;

    // Reset state
    step(); step();
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_data",  64'(data),  64'h0);
    check("rst_pmem1", 64'(pmem1), 64'h0);
    check("rst_pmem2", 64'(pmem2), 64'h0);
    check("rst_ch0",   64'(dbg_state[0]), 64'(CH_IDLE));
    reset = 1'b0;

    // 1: single fetch by core0
    valid[0] = 1'b1; addr[0] = 8'h05;
    step();
    check("t1_pmem1",  64'(pmem1), 64'h05);
    check("t1_ch0",    64'(dbg_state[0]), 64'(CH_READ));
    check("t1_ready0", 64'(ready), 64'h0);
    step();
    check("t1_ready1", 64'(ready), 64'h1);
    check("t1_data",   64'(data[0]), 64'hA1B2);
    valid[0] = 1'b0;
    step();
    check("t1_drop",   64'(ready), 64'h0);
    check("t1_idle",   64'(dbg_state[0]), 64'(CH_IDLE));

    // 2: cores 1 and 2 granted together (rr_ptr now 1)
    valid[1] = 1'b1; addr[1] = 8'h10;
    valid[2] = 1'b1; addr[2] = 8'h11;
    step();
    check("t2_pmem1",  64'(pmem1), 64'h10);
    check("t2_pmem2",  64'(pmem2), 64'h11);
    step();
    check("t2_ready",  64'(ready), 64'h6);
    check("t2_data1",  64'(data[1]), 64'h1010);
    check("t2_data2",  64'(data[2]), 64'h2211);
    valid[1] = 1'b0; valid[2] = 1'b0;
    step();
    check("t2_drop",   64'(ready), 64'h0);

    // 4: core3 holds valid after ready while core0 uses the other channel
    valid[3] = 1'b1; addr[3] = 8'h33;
    step();
    check("t4_pmem1",  64'(pmem1), 64'h33);
    step();
    check("t4_ready3", 64'(ready), 64'h8);
    check("t4_data3",  64'(data[3]), 64'h3333);
    valid[0] = 1'b1; addr[0] = 8'h05;
    step();
    check("t4_h1_rdy", 64'(ready), 64'h8);
    check("t4_h1_ch0", 64'(dbg_state[0]), 64'(CH_RESP));
    check("t4_pmem2",  64'(pmem2), 64'h05);
    check("t4_ch1",    64'(dbg_state[1]), 64'(CH_READ));
    step();
    check("t4_h2_rdy", 64'(ready), 64'h9);
    check("t4_data0",  64'(data[0]), 64'hA1B2);
    check("t4_h2_d3",  64'(data[3]), 64'h3333);
    valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_rdy", 64'(ready), 64'h8);
      check("t4_hold_d3",  64'(data[3]), 64'h3333);
      check("t4_hold_ch0", 64'(dbg_state[0]), 64'(CH_RESP));
    end
    valid[3] = 1'b0;
    step();
    check("t4_drop",   64'(ready), 64'h0);
    check("t4_idle",   64'(dbg_state[0]), 64'(CH_IDLE));

    // 5: asynchronous reset while a fetch is in CH_READ
    valid[1] = 1'b1; addr[1] = 8'h10;
    step();
    check("t5_read",   64'(dbg_state[0]), 64'(CH_READ));
    check("t5_pmem1",  64'(pmem1), 64'h10);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_ready", 64'(ready), 64'h0);
    check("t5_rst_data",  64'(data),  64'h0);
    check("t5_rst_pmem1", 64'(pmem1), 64'h0);
    check("t5_rst_pmem2", 64'(pmem2), 64'h0);
    check("t5_rst_ch0",   64'(dbg_state[0]), 64'(CH_IDLE));
    step();
    reset = 1'b0;
    step();
    check("t5_re_pmem1", 64'(pmem1), 64'h10);
    step();
    check("t5_re_ready", 64'(ready), 64'h2);
    check("t5_re_data",  64'(data[1]), 64'h1010);
    valid[1] = 1'b0;
    step();
    check("t5_re_drop",  64'(ready), 64'h0);

    // 3: all four cores contend from rr_ptr=0, re-requesting after each response
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      addr[k]     = 8'h40 + 8'(k);
      done_cnt[k] = 0;
    end
    valid      = 4'hF;
    prev_ready = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (ready[k] && !prev_ready[k]) begin
          order_q.push_back(k);
          done_cnt[k]++;
          check("t3_data", 64'(data[k]), 64'(mem[8'h40 + 8'(k)]));
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (ready[k])       valid[k] = 1'b0;
        else if (!valid[k]) valid[k] = 1'b1;
      end
      prev_ready = ready;
    end
    check("t3_total", 64'(order_q.size()), 64'd20);
    for (int i = 0; i < 6; i++) begin
      check("t3_order", 64'((i < order_q.size()) ? order_q[i] : 99), 64'(exp_order[i]));
    end
    for (int k = 0; k < 4; k++) check("t3_count", 64'(done_cnt[k]), 64'd5);
    valid = '0;
    step(); step(); step();
    pulse_reset();

    // 6: address change after grant is ignored
    valid[0] = 1'b1; addr[0] = 8'h20;
    step();
    check("t6_pmem1", 64'(pmem1), 64'h20);
    addr[0] = 8'h30;
    step();
    check("t6_ready", 64'(ready), 64'h1);
    check("t6_data",  64'(data[0]), 64'hC020);
    check("t6_pmem1_hold", 64'(pmem1), 64'h20);
    valid[0] = 1'b0;
    step();
    check("t6_drop",  64'(ready), 64'h0);

    // Valid withdrawn before ready: one-cycle ready pulse, then idle
    valid[2] = 1'b1; addr[2] = 8'h11;
    step();
    check("pe_read",  64'(dbg_state[0]), 64'(CH_READ));
    valid[2] = 1'b0;
    step();
    check("pe_ready", 64'(ready), 64'h4);
    check("pe_data",  64'(data[2]), 64'h2211);
    step();
    check("pe_drop",  64'(ready), 64'h0);
    check("pe_idle",  64'(dbg_state[0]), 64'(CH_IDLE));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
